// File: rtl/sample_flow_pkg.sv
// Shared definitions for the Sample-Flow generator recurrence and its receive-side checker.
package sample_flow_pkg;

    localparam logic [7:0] WRAP_THRESH = 8'd50;
    localparam logic [7:0] WRAP_VALUE  = 8'd236;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    // f(A,s): sticks at WRAP_VALUE once A reaches the threshold, else A + s/4 + (A/8)^2 mod 256.
    function automatic logic [7:0] sample_flow_next(input logic [7:0] a, input logic [7:0] s);
        logic [7:0] hi;
        logic [7:0] sq;
        hi = a >> 3;
        sq = hi * hi;
        if (a >= WRAP_THRESH) begin
            return WRAP_VALUE;
        end
        return a + (s >> 2) + sq;
    endfunction

endpackage

// File: rtl/sample_flow_model.sv
// Combinational wrapper around the Sample-Flow recurrence.
module sample_flow_model
    import sample_flow_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] s,
    output logic [7:0] f
);

    assign f = sample_flow_next(a, s);

endmodule

// File: rtl/sample_flow_checker.sv
// Locks onto a Sample-Flow stream by re-seeding a local model from each observed sample,
// then flags mispredictions, counts them and reports the first wrap to 236.
module sample_flow_checker
    import sample_flow_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned MISS_LIMIT = 3,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       sample_in,
    input  logic             sample_valid,
    input  logic [7:0]       step_in,
    output logic [7:0]       predicted,
    output logic             locked,
    output logic             match,
    output logic             mismatch,
    output logic             wrap,
    output logic [ERR_W-1:0] error_count
);

    localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);

    state_t             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [7:0]         prev_q, prev_d;
    logic [7:0]         predicted_q, predicted_d;
    logic               match_q, match_d;
    logic               mismatch_q, mismatch_d;
    logic               wrap_q, wrap_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [7:0]         model_f;
    logic               hit;

    sample_flow_model u_model (
        .a (sample_in),
        .s (step_in),
        .f (model_f)
    );

    assign hit = (sample_in == predicted_q);

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        miss_d      = miss_q;
        prev_d      = prev_q;
        predicted_d = predicted_q;
        err_d       = err_q;
        match_d     = 1'b0;
        mismatch_d  = 1'b0;
        wrap_d      = 1'b0;

        if (sample_valid) begin
            predicted_d = model_f;
            match_d     = hit;
            wrap_d      = (sample_in == WRAP_VALUE) && (prev_q != WRAP_VALUE);
            prev_d      = sample_in;

            case (state_q)
                HUNT: begin
                    if (!hit) begin
                        run_d = '0;
                    end else if (run_q == RUN_W'(LOCK_COUNT - 1)) begin
                        state_d = LOCKED;
                        run_d   = '0;
                        miss_d  = '0;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        miss_d = '0;
                    end else begin
                        mismatch_d = 1'b1;
                        if (err_q != {ERR_W{1'b1}}) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        // Final miss drops lock on the same edge as its mismatch pulse.
                        if (miss_q == MISS_W'(MISS_LIMIT - 1)) begin
                            state_d = HUNT;
                            run_d   = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            run_q       <= '0;
            miss_q      <= '0;
            prev_q      <= '0;
            predicted_q <= '0;
            match_q     <= 1'b0;
            mismatch_q  <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            prev_q      <= prev_d;
            predicted_q <= predicted_d;
            match_q     <= match_d;
            mismatch_q  <= mismatch_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
        end
    end

    assign predicted   = predicted_q;
    assign locked      = (state_q == LOCKED);
    assign match       = match_q;
    assign mismatch    = mismatch_q;
    assign wrap        = wrap_q;
    assign error_count = err_q;

endmodule
